// File: rtl/fifo_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_reader_if
//
// Bundle of the read-side FIFO signals shared between the read controller,
// the write-pointer logic, the synchronous FIFO memory and the output sink.
//
// Parameters
//   ADDR_WIDTH : memory address bits (depth = 2**ADDR_WIDTH)
//   DATA_WIDTH : word width
//
// Signals
//   wr_ptr    : write pointer from the writer (ADDR_WIDTH+1 bits, MSB = wrap)
//   rd_ptr    : read pointer, next word to fetch
//   mem_addr  : memory read address (low bits of rd_ptr)
//   mem_rd    : memory read strobe
//   mem_rdata : memory read data, valid the cycle after mem_rd
//   m_data    : output stream word (buffer head)
//   m_valid   : output stream valid
//   m_ready   : output stream ready from the sink
//   empty     : no unfetched words
//   level     : wr_ptr - rd_ptr (unfetched word count)
//   overrun   : sticky writer-overrun flag (FIFO_READER_OVERRUN_CHECK_EN only)
//
// Modports
//   master : the read controller
//   slave  : the environment (writer, memory, sink)
// -----------------------------------------------------------------------------
interface fifo_reader_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  empty;
   logic [ADDR_WIDTH:0]   level;

`ifdef FIFO_READER_OVERRUN_CHECK_EN
   logic                  overrun;

   modport master (
      input  wr_ptr, mem_rdata, m_ready,
      output rd_ptr, mem_addr, mem_rd, m_data, m_valid, empty, level, overrun
   );

   modport slave (
      output wr_ptr, mem_rdata, m_ready,
      input  rd_ptr, mem_addr, mem_rd, m_data, m_valid, empty, level, overrun
   );
`else
   modport master (
      input  wr_ptr, mem_rdata, m_ready,
      output rd_ptr, mem_addr, mem_rd, m_data, m_valid, empty, level
   );

   modport slave (
      output wr_ptr, mem_rdata, m_ready,
      input  rd_ptr, mem_addr, mem_rd, m_data, m_valid, empty, level
   );
`endif

endinterface

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//
// Read-side controller of a FIFO. Owns the read pointer, detects available
// data by comparing against the writer's pointer, fetches words from a
// synchronous (one-cycle latency) memory and presents them on a valid/ready
// stream through a two-entry output buffer. With a never-stalling sink it
// sustains one word per cycle.
//
// Ports
//   i_clk   : clock (single domain)
//   i_reset : synchronous, active-high reset
//   bus     : fifo_reader_if.master (pointers, memory read port, output stream,
//             empty/level status)
//
// Configuration macro
//   FIFO_READER_OVERRUN_CHECK_EN : when defined, drives bus.overrun, a sticky
//                                  flag set whenever level exceeds the depth.
//
// Output buffer states
//   state     | meaning
//   ----------+--------------------------------------------
//   BUF_EMPTY | no buffered word, m_valid low
//   BUF_ONE   | head slot holds the next output word
//   BUF_TWO   | head and tail slots both hold words
// -----------------------------------------------------------------------------
module fifo_reader #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   fifo_reader_if.master    bus
);

   localparam logic [ADDR_WIDTH:0] LP_PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] LP_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_t;

   buf_state_t            r_state;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic                  r_inflight;
   logic                  r_m_valid;
   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_tail;

   logic                  w_empty;
   logic [ADDR_WIDTH:0]   w_level;
   logic                  w_pop;
   logic                  w_capture;
   logic                  w_fetch;
   logic [1:0]            w_buf_cnt;
   logic [2:0]            w_committed;

   // ---------------------------------------------------------------------------
   // Status: modulo pointer difference stays correct across the wrap.
   // ---------------------------------------------------------------------------
   assign w_empty = (bus.wr_ptr == r_rd_ptr);
   assign w_level = bus.wr_ptr - r_rd_ptr;

   assign w_pop     = r_m_valid & bus.m_ready;
   assign w_capture = r_inflight;

   assign w_buf_cnt = (r_state == BUF_TWO) ? 2'd2 :
                      (r_state == BUF_ONE) ? 2'd1 : 2'd0;

   // Slots that will be occupied after this edge if no new read is issued:
   // current fill plus the word returning from memory, minus the word leaving.
   // A pop only happens with a non-empty buffer, so this never underflows.
   assign w_committed = {1'b0, w_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

   // A new fetch is allowed only if its returning word is guaranteed a slot.
   assign w_fetch = !i_reset && !w_empty && (w_committed < 3'd2);

   // ---------------------------------------------------------------------------
   // Read pointer and in-flight tracking
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_ptr   <= '0;
         r_inflight <= 1'b0;
      end else begin
         if (w_fetch) begin
            r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
         end
         // Clearing on reset drops any read still returning from memory.
         r_inflight <= w_fetch;
      end
   end

   // ---------------------------------------------------------------------------
   // Output buffer FSM. The head slot drives m_data directly so the word is
   // stable while the sink stalls; the tail slot only fills when the head is
   // occupied and not leaving.
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= BUF_EMPTY;
         r_m_valid <= 1'b0;
         r_head    <= '0;
         r_tail    <= '0;
      end else begin
         unique case (r_state)
            BUF_EMPTY: begin
               if (w_capture) begin
                  r_head    <= bus.mem_rdata;
                  r_state   <= BUF_ONE;
                  r_m_valid <= 1'b1;
               end
            end

            BUF_ONE: begin
               if (w_capture && w_pop) begin
                  // head leaves and the returning word takes its place
                  r_head <= bus.mem_rdata;
               end else if (w_capture) begin
                  r_tail  <= bus.mem_rdata;
                  r_state <= BUF_TWO;
               end else if (w_pop) begin
                  r_state   <= BUF_EMPTY;
                  r_m_valid <= 1'b0;
               end
            end

            BUF_TWO: begin
               if (w_pop) begin
                  r_head <= r_tail;
                  if (w_capture) begin
                     r_tail <= bus.mem_rdata;
                  end else begin
                     r_state <= BUF_ONE;
                  end
               end
            end

            default: begin
               r_state   <= BUF_EMPTY;
               r_m_valid <= 1'b0;
            end
         endcase
      end
   end

   // The fetch credit must make a capture into a full, stalled buffer impossible.
   property p_no_capture_into_full;
      @(posedge i_clk) disable iff (i_reset)
         (r_state == BUF_TWO) |-> !(w_capture && !w_pop);
   endproperty
   a_no_capture_into_full : assert property (p_no_capture_into_full);

   // ---------------------------------------------------------------------------
   // Optional sticky writer-overrun flag
   // ---------------------------------------------------------------------------
`ifdef FIFO_READER_OVERRUN_CHECK_EN
   logic r_overrun;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_overrun <= 1'b0;
      end else if (w_level > LP_DEPTH) begin
         r_overrun <= 1'b1;
      end
   end

   assign bus.overrun = r_overrun;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.rd_ptr   = r_rd_ptr;
   assign bus.mem_addr = r_rd_ptr[ADDR_WIDTH-1:0];
   assign bus.mem_rd   = w_fetch;
   assign bus.m_data   = r_head;
   assign bus.m_valid  = r_m_valid;
   assign bus.empty    = w_empty;
   assign bus.level    = w_level;

endmodule

// File: tb/tb_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_reader
//
// Drives fifo_reader with a behavioural writer + synchronous memory. Every
// written word is pushed into a scoreboard queue; an independent monitor pops
// and compares whenever the DUT hands a word to the sink, and also checks that
// a stalled output holds still.
// -----------------------------------------------------------------------------
module tb_fifo_reader;

   localparam int AW = 3;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fifo_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   fifo_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // ---------------------------------------------------------------------------
   // Writer and memory model
   // ---------------------------------------------------------------------------
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          wr_en     = 1'b0;
   logic [DW-1:0] wr_data   = '0;
   int            bulk_n    = 0;
   logic [DW-1:0] bulk_data [4];
   logic          force_en  = 1'b0;
   logic [AW:0]   force_val = '0;

   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
      if (rst) begin
         bus.wr_ptr <= '0;
      end else if (force_en) begin
         bus.wr_ptr <= force_val;
      end else if (wr_en) begin
         mem[bus.wr_ptr[AW-1:0]] <= wr_data;
         bus.wr_ptr <= bus.wr_ptr + (AW+1)'(1);
      end else if (bulk_n > 0) begin
         for (int k = 0; k < 4; k++)
            if (k < bulk_n) mem[AW'(bus.wr_ptr + (AW+1)'(k))] <= bulk_data[k];
         bus.wr_ptr <= bus.wr_ptr + (AW+1)'(bulk_n);
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard and checking
   // ---------------------------------------------------------------------------
   logic [DW-1:0] sb_q [$];
   int n_tests = 0;
   int n_fail  = 0;
   int n_pops  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   logic          prev_valid = 1'b0;
   logic          prev_ready = 1'b0;
   logic          prev_rst   = 1'b1;
   logic [DW-1:0] prev_data  = '0;
   logic [DW-1:0] exp_d;

   always @(negedge clk) begin
      if (!rst) begin
         if (prev_valid && !prev_ready && !prev_rst) begin
            chk("stall_hold_valid", 32'(bus.m_valid), 32'(1));
            chk("stall_hold_data", 32'(bus.m_data), 32'(prev_data));
         end
         if (bus.m_valid && bus.m_ready) begin
            n_pops++;
            if (sb_q.size() == 0) begin
               chk("unexpected_pop", 32'(bus.m_data), 32'hFFFF_FFFF);
            end else begin
               exp_d = sb_q.pop_front();
               chk("pop_data", 32'(bus.m_data), 32'(exp_d));
            end
         end
      end
      prev_valid = bus.m_valid;
      prev_ready = bus.m_ready;
      prev_rst   = rst;
      prev_data  = bus.m_data;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (called with time at posedge + 1)
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      sb_q.push_back(d);
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      wr_en    = 1'b0;
      bulk_n   = 0;
      force_en = 1'b0;
      sb_q.delete();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   int            pops0, nrd, run, maxrun, nvalid, g;
   logic [AW-1:0] addr_q [$];
   logic [AW:0]   lvl;
   logic [DW-1:0] d;

   initial begin
      bus.m_ready = 1'b0;
      #1;
      do_reset();

      // reset state
      @(negedge clk);
      chk("rst_rd_ptr", 32'(bus.rd_ptr), 32'(0));
      chk("rst_m_valid", 32'(bus.m_valid), 32'(0));
      chk("rst_m_data", 32'(bus.m_data), 32'(0));
      chk("rst_mem_rd", 32'(bus.mem_rd), 32'(0));
      chk("rst_empty", 32'(bus.empty), 32'(1));
      chk("rst_level", 32'(bus.level), 32'(0));
      tick();

      // single word: fetch in N, valid in N+2
      bus.m_ready = 1'b1;
      write_word(8'hA5);
      @(negedge clk);
      chk("single_mem_rd_N", 32'(bus.mem_rd), 32'(1));
      chk("single_mem_addr_N", 32'(bus.mem_addr), 32'(0));
      chk("single_valid_N", 32'(bus.m_valid), 32'(0));
      @(negedge clk);
      chk("single_valid_N1", 32'(bus.m_valid), 32'(0));
      @(negedge clk);
      chk("single_valid_N2", 32'(bus.m_valid), 32'(1));
      chk("single_data_N2", 32'(bus.m_data), 32'(8'hA5));
      @(negedge clk);
      chk("single_rd_ptr", 32'(bus.rd_ptr), 32'(1));
      chk("single_empty", 32'(bus.empty), 32'(1));
      tick();

      // streaming: 8 back-to-back words
      do_reset();
      bus.m_ready = 1'b1;
      pops0 = n_pops; nrd = 0; run = 0; maxrun = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) write_word(DW'(8'h10 + i));
         end
         begin
            for (int c = 0; c < 16; c++) begin
               @(negedge clk);
               if (bus.mem_rd) begin
                  nrd++; run++;
                  if (run > maxrun) maxrun = run;
               end else begin
                  run = 0;
               end
            end
         end
      join
      chk("stream_mem_rd_count", 32'(nrd), 32'(8));
      chk("stream_mem_rd_run", 32'(maxrun), 32'(8));
      chk("stream_rd_ptr", 32'(bus.rd_ptr), 32'(8));
      chk("stream_level", 32'(bus.level), 32'(0));
      chk("stream_pops", 32'(n_pops - pops0), 32'(8));
      tick();

      // backpressure: 4 words, sink stalled
      do_reset();
      bus.m_ready = 1'b0;
      for (int i = 0; i < 4; i++) write_word(DW'(8'h30 + i));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", 32'(bus.m_valid), 32'(1));
         chk("bp_head", 32'(bus.m_data), 32'(8'h30));
         chk("bp_rd_ptr", 32'(bus.rd_ptr), 32'(2));
      end
      chk("bp_level", 32'(bus.level), 32'(2));
      tick();
      pops0 = n_pops;
      bus.m_ready = 1'b1;
      for (int c = 0; c < 8; c++) tick();
      chk("bp_pops", 32'(n_pops - pops0), 32'(4));
      chk("bp_rd_ptr_end", 32'(bus.rd_ptr), 32'(4));
      chk("bp_empty_end", 32'(bus.empty), 32'(1));

      // wrap: preload pointers to 14, then commit 4 words at once
      do_reset();
      bus.m_ready = 1'b1;
      for (int i = 0; i < 14; i++) write_word(DW'(8'h40 + i));
      for (int c = 0; c < 6; c++) tick();
      chk("wrap_pre_rd_ptr", 32'(bus.rd_ptr), 32'(14));
      chk("wrap_pre_level", 32'(bus.level), 32'(0));
      pops0 = n_pops;
      for (int i = 0; i < 4; i++) begin
         bulk_data[i] = DW'(8'h50 + i);
         sb_q.push_back(bulk_data[i]);
      end
      bulk_n = 4;
      tick();
      bulk_n = 0;
      addr_q.delete();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0) chk("wrap_level", 32'(bus.level), 32'(4));
         if (bus.mem_rd) addr_q.push_back(bus.mem_addr);
      end
      chk("wrap_addr_count", 32'(addr_q.size()), 32'(4));
      for (int i = 0; i < 4 && i < addr_q.size(); i++)
         chk("wrap_addr_seq", 32'(addr_q[i]), 32'((14 + i) % 8));
      chk("wrap_rd_ptr_end", 32'(bus.rd_ptr), 32'(2));
      chk("wrap_pops", 32'(n_pops - pops0), 32'(4));
      tick();

      // reset while a read is in flight
      do_reset();
      bus.m_ready = 1'b0;
      write_word(8'h61);
      write_word(8'h62);
      @(negedge clk);
      chk("mid_rst_fetching", 32'(bus.mem_rd), 32'(1));
      tick();
      rst = 1'b1;
      sb_q.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 32'(bus.m_valid), 32'(0));
      chk("mid_rst_rd_ptr", 32'(bus.rd_ptr), 32'(0));
      chk("mid_rst_empty", 32'(bus.empty), 32'(1));
      tick();
      bus.m_ready = 1'b1;
      nvalid = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.m_valid) nvalid++;
      end
      chk("mid_rst_no_late_word", 32'(nvalid), 32'(0));
      tick();

`ifdef FIFO_READER_OVERRUN_CHECK_EN
      // overrun: level 9 > depth 8 sets a sticky flag
      do_reset();
      bus.m_ready = 1'b0;
      @(negedge clk);
      chk("ovr_reset", 32'(bus.overrun), 32'(0));
      tick();
      force_en = 1'b1; force_val = (AW+1)'(9);
      tick();
      force_en = 1'b0;
      tick();
      @(negedge clk);
      chk("ovr_set", 32'(bus.overrun), 32'(1));
      tick();
      force_en = 1'b1; force_val = '0;
      tick();
      force_en = 1'b0;
      for (int c = 0; c < 3; c++) tick();
      @(negedge clk);
      chk("ovr_sticky", 32'(bus.overrun), 32'(1));
      tick();
      do_reset();
      @(negedge clk);
      chk("ovr_cleared", 32'(bus.overrun), 32'(0));
      tick();
`endif

      // randomized traffic against the scoreboard
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.m_ready = ($urandom_range(0, 3) != 0);
         lvl = bus.wr_ptr - bus.rd_ptr;
         if ($urandom_range(0, 2) != 0 && lvl < (AW+1)'(8)) begin
            d = DW'($urandom);
            wr_en = 1'b1; wr_data = d;
            sb_q.push_back(d);
         end else begin
            wr_en = 1'b0;
         end
         tick();
      end
      wr_en = 1'b0;
      bus.m_ready = 1'b1;
      for (g = 0; g < 100 && (sb_q.size() != 0 || bus.m_valid); g++) tick();
      chk("rand_drained", 32'(sb_q.size()), 32'(0));
      @(negedge clk);
      chk("rand_empty", 32'(bus.empty), 32'(1));
      chk("rand_valid_end", 32'(bus.m_valid), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
